// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-entry skid buffer, branch redirect and stale-request drain
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);
    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;
    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n, addr_n, inst_n, pc_n;
    logic [31:0] skid_inst, skid_inst_n, skid_pc, skid_pc_n;
    logic        valid_n, slot_free;
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign slot_free = !inst_valid || !stall;
    // state register; reset abandons any outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state and next datapath values; a redirect outranks stall and ack
    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        addr_n      = imem_addr;
        inst_n      = inst;
        pc_n        = pc;
        valid_n     = slot_free ? 1'b0 : inst_valid;
        skid_inst_n = skid_inst;
        skid_pc_n   = skid_pc;
        if (isBranchTaken) begin
            valid_n    = 1'b0;
            fetch_pc_n = branchPC;
            case (state)
                FETCH: begin
                    if (imem_ack) addr_n = branchPC;
                    else          state_n = DRAIN;
                end
                DRAIN: begin
                    if (imem_ack) begin
                        addr_n  = branchPC;
                        state_n = FETCH;
                    end
                end
                default: begin
                    addr_n  = branchPC;
                    state_n = FETCH;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    addr_n  = fetch_pc;
                    state_n = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        if (slot_free) begin
                            inst_n  = imem_rdata;
                            pc_n    = imem_addr;
                            valid_n = 1'b1;
                            addr_n  = fetch_pc + 32'd4;
                        end else begin
                            skid_inst_n = imem_rdata;
                            skid_pc_n   = imem_addr;
                            state_n     = FULL;
                        end
                    end
                end
                FULL: begin
                    if (slot_free) begin
                        inst_n  = skid_inst;
                        pc_n    = skid_pc;
                        valid_n = 1'b1;
                        addr_n  = fetch_pc;
                        state_n = FETCH;
                    end
                end
                default: begin
                    if (imem_ack) begin
                        addr_n  = fetch_pc;
                        state_n = FETCH;
                    end
                end
            endcase
        end
    end
    // datapath registers: fetch PC, request address, IF/OF latch and skid buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            imem_addr  <= RESET_PC;
            inst       <= '0;
            pc         <= '0;
            inst_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            imem_addr  <= addr_n;
            inst       <= inst_n;
            pc         <= pc_n;
            inst_valid <= valid_n;
            skid_inst  <= skid_inst_n;
            skid_pc    <= skid_pc_n;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized stream checked against an in-order fetch model
module tb_fetch_stage;
    logic        clk, rst, br, stall, ack;
    logic [31:0] bpc, rdata;
    logic        req, valid;
    logic [31:0] addr, inst, pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_inst, w_pc;
    int vectors, miscompares;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign rdata = mem_f(addr);

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .isBranchTaken(br), .branchPC(bpc), .stall(stall),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .inst_valid(valid), .inst(inst), .pc(pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .isBranchTaken(1'b0), .branchPC(32'h0), .stall(1'b0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_rdata(32'h0),
        .inst_valid(w_valid), .inst(w_inst), .pc(w_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        br = 0; bpc = 0; stall = 0; ack = 0;
        @(negedge clk);
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        br = 0; bpc = 0; stall = 0; ack = 0;
        rst = 1;
        #1;
        vectors++;
        if ({req, valid, inst, pc, addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got req=%b valid=%b inst=%h pc=%h addr=%h expected 0 0 0 0 0", req, valid, inst, pc, addr);
        end
        vectors++;
        if (w_addr !== 32'hFFFF_FFF8 || w_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pc_param: got addr=%h req=%b expected fffffff8 0", w_addr, w_req);
        end
        step();
        rst = 0;
        step();
        vectors++;
        if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_to_fetch: got req=%b addr=%h valid=%b expected 1 00000000 0", req, addr, valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        step();
        ack = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if ({req, valid, pc, inst, addr} !== {1'b1, 1'b1, 32'(4 * k), mem_f(32'(4 * k)), 32'(4 * k + 4)}) begin
                miscompares++;
                $display("FAIL stream_%0d: got req=%b valid=%b pc=%h inst=%h addr=%h expected 1 1 %h %h %h",
                         k, req, valid, pc, inst, addr, 32'(4 * k), mem_f(32'(4 * k)), 32'(4 * k + 4));
            end
        end
        ack = 0;
    endtask

    task automatic test_stall_skid();
        do_reset();
        step();
        ack = 1;
        step();
        step();
        stall = 1;
        step();
        vectors++;
        if ({req, valid, pc} !== {1'b0, 1'b1, 32'h4}) begin
            miscompares++;
            $display("FAIL skid_full: got req=%b valid=%b pc=%h expected 0 1 00000004", req, valid, pc);
        end
        step();
        vectors++;
        if ({req, valid, pc, inst} !== {1'b0, 1'b1, 32'h4, mem_f(32'h4)}) begin
            miscompares++;
            $display("FAIL skid_hold: got req=%b valid=%b pc=%h inst=%h expected 0 1 00000004 %h", req, valid, pc, inst, mem_f(32'h4));
        end
        stall = 0;
        ack = 0;
        step();
        vectors++;
        if ({req, valid, pc, inst, addr} !== {1'b1, 1'b1, 32'h8, mem_f(32'h8), 32'hC}) begin
            miscompares++;
            $display("FAIL skid_release: got req=%b valid=%b pc=%h inst=%h addr=%h expected 1 1 00000008 %h 0000000c",
                     req, valid, pc, inst, addr, mem_f(32'h8));
        end
        ack = 1;
        step();
        vectors++;
        if ({valid, pc, addr} !== {1'b1, 32'hC, 32'h10}) begin
            miscompares++;
            $display("FAIL skid_resume: got valid=%b pc=%h addr=%h expected 1 0000000c 00000010", valid, pc, addr);
        end
        ack = 0;
    endtask

    task automatic test_branch_drain();
        do_reset();
        step();
        ack = 1;
        repeat (4) step();
        ack = 0;
        br = 1;
        bpc = 32'h100;
        step();
        br = 0;
        vectors++;
        if ({req, valid, addr} !== {1'b1, 1'b0, 32'h10}) begin
            miscompares++;
            $display("FAIL drain_enter: got req=%b valid=%b addr=%h expected 1 0 00000010", req, valid, addr);
        end
        step();
        step();
        vectors++;
        if ({req, valid, addr} !== {1'b1, 1'b0, 32'h10}) begin
            miscompares++;
            $display("FAIL drain_wait: got req=%b valid=%b addr=%h expected 1 0 00000010", req, valid, addr);
        end
        ack = 1;
        step();
        vectors++;
        if ({req, valid, addr} !== {1'b1, 1'b0, 32'h100}) begin
            miscompares++;
            $display("FAIL drain_discard: got req=%b valid=%b addr=%h expected 1 0 00000100", req, valid, addr);
        end
        step();
        vectors++;
        if ({valid, pc, inst, addr} !== {1'b1, 32'h100, mem_f(32'h100), 32'h104}) begin
            miscompares++;
            $display("FAIL drain_target: got valid=%b pc=%h inst=%h addr=%h expected 1 00000100 %h 00000104",
                     valid, pc, inst, addr, mem_f(32'h100));
        end
        ack = 0;
    endtask

    task automatic test_branch_skid();
        do_reset();
        step();
        ack = 1;
        step();
        stall = 1;
        step();
        ack = 0;
        br = 1;
        bpc = 32'h200;
        step();
        br = 0;
        vectors++;
        if ({req, valid, addr} !== {1'b1, 1'b0, 32'h200}) begin
            miscompares++;
            $display("FAIL branch_skid: got req=%b valid=%b addr=%h expected 1 0 00000200", req, valid, addr);
        end
        stall = 0;
        ack = 1;
        step();
        vectors++;
        if ({valid, pc, inst} !== {1'b1, 32'h200, mem_f(32'h200)}) begin
            miscompares++;
            $display("FAIL branch_skid_next: got valid=%b pc=%h inst=%h expected 1 00000200 %h", valid, pc, inst, mem_f(32'h200));
        end
        ack = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (w_req !== 1'b1 || w_addr !== exp_a[k]) begin
                miscompares++;
                $display("FAIL wrap_%0d: got req=%b addr=%h expected 1 %h", k, w_req, w_addr, exp_a[k]);
            end
        end
        vectors++;
        if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_pc: got valid=%b pc=%h expected 1 fffffffc", w_valid, w_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        ack = 1;
        step();
        #1 rst = 1;
        #1;
        vectors++;
        if ({req, valid, addr, pc} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL async_reset: got req=%b valid=%b addr=%h pc=%h expected 0 0 0 0", req, valid, addr, pc);
        end
        ack = 0;
        step();
        rst = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr;
        logic        prev_wait;
        int          consumed;
        exp_pc = 32'h0;
        prev_wait = 0;
        prev_addr = 0;
        consumed = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (prev_wait) begin
                vectors++;
                if (req !== 1'b1 || addr !== prev_addr) begin
                    miscompares++;
                    $display("FAIL rnd_addr_stable cycle %0d: got req=%b addr=%h expected 1 %h", i, req, addr, prev_addr);
                end
            end
            br = ($urandom_range(0, 15) == 0);
            bpc = $urandom() & 32'hFFFF_FFFC;
            stall = ($urandom_range(0, 2) == 0);
            ack = req && ($urandom_range(0, 1) == 1);
            if (br) exp_pc = bpc;
            else if (valid && !stall) begin
                vectors++;
                if (pc !== exp_pc || inst !== mem_f(exp_pc)) begin
                    miscompares++;
                    $display("FAIL rnd_consume cycle %0d: got pc=%h inst=%h expected %h %h", i, pc, inst, exp_pc, mem_f(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            prev_wait = req && !ack;
            prev_addr = addr;
            step();
        end
        br = 0; stall = 0; ack = 0;
        vectors++;
        if (consumed < 300) begin
            miscompares++;
            $display("FAIL rnd_progress: got %0d instructions expected at least 300", consumed);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_branch_drain();
        test_branch_skid();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
